// File: rtl/mem_ctrl_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_mp_if
//  Description : Requester-side bus bundle for the multi-port memory controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_ctrl_mp_if #(
    parameter int NCH    = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [NCH-1:0]            req_valid;
    logic [NCH-1:0]            req_ready;
    logic [NCH-1:0]            req_we;
    logic [NCH*ADDR_W-1:0]     req_addr;
    logic [NCH*DATA_W-1:0]     req_wdata;
    logic [NCH*(DATA_W/8)-1:0] req_be;
    logic [NCH-1:0]            rsp_valid;
    logic [NCH*DATA_W-1:0]     rsp_rdata;
    logic [NCH-1:0]            rsp_err;
    logic                      busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl_mp.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_mp
//  Description : Round-robin multi-port controller in front of a word RAM with
//                base-window translation, byte enables and fixed read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl_mp #(
    parameter int                NCH    = 2,
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 32,
    parameter int                MEM_AW = 10,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int                RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_ctrl_mp_if.slave  bus
);
    localparam int                c_NB         = DATA_W / 8;
    localparam int                c_LSB        = $clog2(c_NB);
    localparam int                c_PW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int                c_LAST       = RD_LAT - 1;
    localparam logic [63:0]       c_SPAN       = 64'(c_NB) << MEM_AW;
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(c_NB - 1);

    logic [DATA_W-1:0] r_mem [2**MEM_AW];
    logic [c_PW-1:0]   r_ptr;
    logic [RD_LAT-1:0] r_pv;
    logic [RD_LAT-1:0] r_perr;
    logic [c_PW-1:0]   r_pch   [RD_LAT];
    logic [DATA_W-1:0] r_pdata [RD_LAT];

    logic              w_found;
    logic [c_PW-1:0]   w_cand;
    logic [c_PW-1:0]   w_gnt;
    logic [c_PW-1:0]   w_ptr_nxt;
    logic              w_acc;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W:0]   w_diff;
    logic [ADDR_W-1:0] w_off;
    logic [DATA_W-1:0] w_wdata;
    logic [c_NB-1:0]   w_be;
    logic              w_err;
    logic [MEM_AW-1:0] w_idx;
    logic [DATA_W-1:0] w_rdata;

    // First valid channel at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_cand = c_PW'((int'(r_ptr) + k) % NCH);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    // No grant may be issued while the block is held in reset.
    assign w_acc     = w_found & reset;
    assign w_ptr_nxt = (w_gnt == c_PW'(NCH - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (w_acc) begin
            bus.req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_we    = bus.req_we[w_gnt];
    assign w_addr  = bus.req_addr[w_gnt*ADDR_W +: ADDR_W];
    assign w_wdata = bus.req_wdata[w_gnt*DATA_W +: DATA_W];
    assign w_be    = bus.req_be[w_gnt*c_NB +: c_NB];

    // The extra MSB of the difference is the borrow, i.e. addr < BASE.
    assign w_diff  = {1'b0, w_addr} - {1'b0, BASE};
    assign w_off   = w_diff[ADDR_W-1:0];
    assign w_err   = w_diff[ADDR_W] | (64'(w_off) >= c_SPAN) | ((w_off & c_ALIGN_MASK) != '0);
    assign w_idx   = MEM_AW'(w_off >> c_LSB);
    assign w_rdata = (w_we || w_err) ? '0 : r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_acc && w_we && !w_err) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr  <= '0;
            r_pv   <= '0;
            r_perr <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_pch[s]   <= '0;
                r_pdata[s] <= '0;
            end
        end else begin
            if (w_acc) begin
                r_ptr <= w_ptr_nxt;
            end
            r_pv[0]    <= w_acc;
            r_perr[0]  <= w_acc & w_err;
            r_pch[0]   <= w_gnt;
            r_pdata[0] <= w_acc ? w_rdata : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pv[s]    <= r_pv[s-1];
                r_perr[s]  <= r_perr[s-1];
                r_pch[s]   <= r_pch[s-1];
                r_pdata[s] <= r_pdata[s-1];
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_err   = '0;
        bus.rsp_rdata = '0;
        if (r_pv[c_LAST]) begin
            bus.rsp_valid[r_pch[c_LAST]]                   = 1'b1;
            bus.rsp_err[r_pch[c_LAST]]                     = r_perr[c_LAST];
            bus.rsp_rdata[r_pch[c_LAST]*DATA_W +: DATA_W] = r_pdata[c_LAST];
        end
    end

    assign bus.busy = |r_pv;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl_mp
//  Description : Randomised and directed bench for mem_ctrl_mp against a
//                byte-array / response-queue reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl_mp;
    localparam int          NCH    = 2;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          MEM_AW = 6;
    localparam int          RD_LAT = 3;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          NB     = DATA_W / 8;
    localparam int          BYTES  = NB * (2**MEM_AW);
    localparam int          OW     = 3*NCH + NCH*DATA_W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_ctrl_mp_if #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_ctrl_mp #(
        .NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .MEM_AW(MEM_AW), .BASE(BASE), .RD_LAT(RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        int          ch;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [7:0]  mem_b [BYTES];
    int          ptr_m = 0;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    int          last_gnt;

    logic [NCH-1:0]        obs_ready, obs_valid, obs_err;
    logic [NCH*DATA_W-1:0] obs_rdata;
    logic                  obs_busy;
    logic [OW-1:0]         obs_all, exp_all;

    task automatic set_req(int ch, bit v, bit we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
        bus.req_valid[ch]               = v;
        bus.req_we[ch]                  = we;
        bus.req_addr[ch*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[ch*DATA_W +: DATA_W] = wd;
        bus.req_be[ch*NB +: NB]         = be;
    endtask

    task automatic idle_all();
        for (int c = 0; c < NCH; c++) set_req(c, 0, 0, '0, '0, '0);
    endtask

    function automatic bit addr_err(logic [31:0] a);
        longint x = a;
        longint b = BASE;
        return (x < b) || (x - b >= BYTES) || ((x - b) % NB != 0);
    endfunction

    // One clock of the reference: predict outputs, capture DUT, apply accept.
    task automatic tick();
        int             g;
        rsp_t           r;
        logic [NCH-1:0] er, ev, ee;
        logic [NCH*DATA_W-1:0] ed;
        logic           eb;
        logic [31:0]    a, wd, d;
        logic [3:0]     be;
        bit             e;
        int             o;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            int c = (ptr_m + k) % NCH;
            if (g < 0 && bus.req_valid[c]) g = c;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = '0; ee = '0; ed = '0;
        eb = (exp_q.size() != 0);
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            ev[r.ch] = 1'b1;
            ee[r.ch] = r.err;
            ed[r.ch*DATA_W +: DATA_W] = r.data;
        end
        obs_ready = bus.req_ready;
        obs_valid = bus.rsp_valid;
        obs_err   = bus.rsp_err;
        obs_rdata = bus.rsp_rdata;
        obs_busy  = bus.busy;
        obs_all   = {obs_ready, obs_valid, obs_err, obs_rdata, obs_busy};
        exp_all   = {er, ev, ee, ed, eb};
        last_gnt  = g;
        @(posedge clk);
        if (g >= 0) begin
            a  = bus.req_addr[g*ADDR_W +: ADDR_W];
            wd = bus.req_wdata[g*DATA_W +: DATA_W];
            be = bus.req_be[g*NB +: NB];
            e  = addr_err(a);
            o  = int'(a - BASE);
            d  = '0;
            if (!e) begin
                if (bus.req_we[g]) begin
                    for (int b = 0; b < NB; b++) if (be[b]) mem_b[o+b] = wd[b*8 +: 8];
                end else begin
                    d = {mem_b[o+3], mem_b[o+2], mem_b[o+1], mem_b[o]};
                end
            end
            r.due = cyc + RD_LAT; r.ch = g; r.err = e; r.data = d;
            exp_q.push_back(r);
            ptr_m = (g + 1) % NCH;
        end
        cyc++;
        #1;
    endtask

    task automatic apply_reset(int cycles);
        reset = 1'b0;
        exp_q.delete();
        ptr_m = 0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) set_req(c, 1, 0, BASE, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b valid=%b err=%b rdata=%h busy=%b, want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.busy);
        end
        idle_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int t = 0; t < 2**MEM_AW + RD_LAT + 1; t++) begin
            if (t < 2**MEM_AW) set_req(0, 1, 1, BASE + 32'(4*t), $urandom, 4'hF);
            else idle_all();
            tick();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL fill cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
        end
    endtask

    task automatic test_write_read();
        for (int t = 0; t < RD_LAT + 3; t++) begin
            if (t == 0)      set_req(0, 1, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
            else if (t == 1) set_req(0, 1, 0, BASE + 32'h10, '0, '0);
            else             idle_all();
            tick();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL write_read_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (t == RD_LAT) begin
                total++;
                if (obs_valid !== 2'b01 || obs_err !== 2'b00 || obs_rdata !== '0) begin
                    bad++; $display("FAIL write_ack got valid=%b err=%b rdata=%h want 01/00/0", obs_valid, obs_err, obs_rdata);
                end
            end
            if (t == RD_LAT + 1) begin
                total++;
                if (obs_valid !== 2'b01 || obs_err !== 2'b00 || obs_rdata[31:0] !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL read_back got valid=%b err=%b rdata=%h want 01/00/deadbeef", obs_valid, obs_err, obs_rdata);
                end
            end
        end
    endtask

    task automatic test_byte_enable();
        for (int t = 0; t < RD_LAT + 4; t++) begin
            if (t == 0)      set_req(0, 1, 1, BASE + 32'h20, 32'h11223344, 4'hF);
            else if (t == 1) set_req(0, 1, 1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101);
            else if (t == 2) set_req(0, 1, 0, BASE + 32'h20, '0, '0);
            else             idle_all();
            tick();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL byte_en_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (t == RD_LAT + 2) begin
                total++;
                if (obs_valid !== 2'b01 || obs_rdata[31:0] !== 32'h11BB33DD) begin
                    bad++; $display("FAIL byte_en got valid=%b rdata=%h want 01/11bb33dd", obs_valid, obs_rdata);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [NCH-1:0] want;
        idle_all();
        apply_reset(2);
        for (int t = 0; t < RD_LAT + 5; t++) begin
            if (t < 4) begin
                set_req(0, 1, 0, BASE + 32'h0, '0, '0);
                set_req(1, 1, 0, BASE + 32'h4, '0, '0);
            end else idle_all();
            tick();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL contention_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (t < 4) begin
                want = (t % 2 == 0) ? 2'b01 : 2'b10;
                total++;
                if (obs_ready !== want) begin
                    bad++; $display("FAIL rr_grant t=%0d got=%b want=%b", t, obs_ready, want);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] w0;
        w0 = {mem_b[3], mem_b[2], mem_b[1], mem_b[0]};
        for (int t = 0; t < RD_LAT + 5; t++) begin
            if (t == 0)      set_req(1, 1, 0, BASE + 32'(BYTES), '0, '0);
            else if (t == 1) set_req(1, 1, 1, BASE + 32'h2, 32'hFFFFFFFF, 4'hF);
            else if (t == 2) set_req(1, 1, 0, BASE - 32'h4, '0, '0);
            else if (t == 3) set_req(1, 1, 0, BASE, '0, '0);
            else             idle_all();
            tick();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL error_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (t >= RD_LAT && t < RD_LAT + 3) begin
                total++;
                if (obs_valid !== 2'b10 || obs_err !== 2'b10 || obs_rdata !== '0) begin
                    bad++; $display("FAIL error_rsp t=%0d got valid=%b err=%b rdata=%h want 10/10/0", t, obs_valid, obs_err, obs_rdata);
                end
            end
            if (t == RD_LAT + 3) begin
                total++;
                if (obs_err !== 2'b00 || obs_rdata[63:32] !== w0) begin
                    bad++; $display("FAIL word0_intact got err=%b rdata=%h want 00/%h", obs_err, obs_rdata[63:32], w0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < RD_LAT + 9; t++) begin
            if (t < 4)      set_req(0, 1, 1, BASE + 32'(4*t), 32'(t + 1), 4'hF);
            else if (t < 8) set_req(0, 1, 0, BASE + 32'(4*(t-4)), '0, '0);
            else            idle_all();
            tick();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (t >= RD_LAT + 4 && t < RD_LAT + 8) begin
                total++;
                if (obs_valid !== 2'b01 || obs_rdata[31:0] !== 32'(t - RD_LAT - 3)) begin
                    bad++; $display("FAIL b2b_data t=%0d got valid=%b rdata=%h want 01/%0d", t, obs_valid, obs_rdata[31:0], t - RD_LAT - 3);
                end
            end
            total++;
            if (obs_busy !== (t >= 1 && t <= RD_LAT + 7)) begin
                bad++; $display("FAIL b2b_busy t=%0d got=%b want=%b", t, obs_busy, (t >= 1 && t <= RD_LAT + 7));
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int t = 0; t < 2; t++) begin
            set_req(0, 1, 0, BASE + 32'(4*t), '0, '0);
            tick();
        end
        idle_all();
        apply_reset(2);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
            bad++; $display("FAIL reset_flush got busy=%b valid=%b want 0/00", bus.busy, bus.rsp_valid);
        end
        for (int t = 0; t < RD_LAT + 2; t++) begin
            tick();
            total++;
            if (obs_valid !== '0 || obs_busy !== 1'b0 || obs_all !== exp_all) begin
                bad++; $display("FAIL reset_no_rsp t=%0d got valid=%b busy=%b all=%h", t, obs_valid, obs_busy, obs_all);
            end
        end
        set_req(0, 1, 0, BASE, '0, '0);
        set_req(1, 1, 0, BASE + 32'h4, '0, '0);
        tick();
        total++;
        if (obs_ready !== 2'b01) begin
            bad++; $display("FAIL reset_ptr got ready=%b want 01", obs_ready);
        end
        idle_all();
        repeat (RD_LAT + 1) tick();
    endtask

    task automatic test_random();
        bit          pv  [NCH];
        bit          pwe [NCH];
        logic [31:0] pa  [NCH];
        logic [31:0] pd  [NCH];
        logic [3:0]  pb  [NCH];
        for (int c = 0; c < NCH; c++) pv[c] = 0;
        for (int t = 0; t < 400 + RD_LAT + 1; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if (t >= 400) pv[c] = 0;
                else if (!pv[c] && $urandom_range(0, 1) == 1) begin
                    pv[c]  = 1;
                    pwe[c] = $urandom_range(0, 1) == 1;
                    pd[c]  = $urandom;
                    pb[c]  = 4'($urandom);
                    case ($urandom_range(0, 15))
                        0:       pa[c] = BASE - 32'(4 * $urandom_range(1, 4));
                        1:       pa[c] = BASE + 32'(BYTES + 4 * $urandom_range(0, 8));
                        2:       pa[c] = BASE + 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
                        default: pa[c] = BASE + 32'(4 * $urandom_range(0, 63));
                    endcase
                end else if (pv[c] && $urandom_range(0, 7) == 0) begin
                    pv[c] = 0;
                end
                set_req(c, pv[c], pwe[c], pa[c], pd[c], pb[c]);
            end
            tick();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (last_gnt >= 0) pv[last_gnt] = 0;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_byte_enable();
        test_contention();
        test_errors();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
